segre_history_file: RTL and testbench

In-order completion tracker (history file) sitting directly downstream of the execution pipelines. Decode allocates one entry per issued instruction, recording the destination register's old value. The EX, MEM and RVM pipelines report completion by instruction ID, and entries retire strictly in program order. An exception on the oldest entry triggers a serial register-file rollback, youngest first, followed by an exception redirect.

---
 rtl/segre_history_file.sv | 222 ++++++++++++++++++++++
 tb/tb_segre_history_file.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/segre_history_file.sv
// In-order completion tracker: allocates per issued instruction, retires in program order,
// and on an exception at head rolls the register file back youngest-first, then redirects.
// Optional feature macro: SEGRE_HF_PERF_CNT_EN (retired / stall performance counters).
module segre_history_file #(
  parameter int HF_SIZE   = 8,
  parameter int ADDR_SIZE = 32,
  parameter int WORD_SIZE = 32,
  parameter int REG_SIZE  = 5,
  parameter bit ALLOC_ASSERT_EN = 1'b1,
  localparam int HF_PTR = $clog2(HF_SIZE)
) (
  input  logic                 clk_i,
  input  logic                 rsn_i,
  input  logic                 alloc_i,
  input  logic [ADDR_SIZE-1:0] alloc_pc_i,
  input  logic                 alloc_rf_we_i,
  input  logic [REG_SIZE-1:0]  alloc_rf_waddr_i,
  input  logic [WORD_SIZE-1:0] alloc_old_data_i,
  output logic [HF_PTR-1:0]    alloc_id_o,
  output logic                 full_o,
  input  logic                 ex_done_i,
  input  logic                 mem_done_i,
  input  logic                 rvm_done_i,
  input  logic [HF_PTR-1:0]    ex_id_i,
  input  logic [HF_PTR-1:0]    mem_id_i,
  input  logic [HF_PTR-1:0]    rvm_id_i,
  input  logic                 mem_exc_i,
  output logic                 retire_valid_o,
  output logic [HF_PTR-1:0]    retire_id_o,
  output logic                 rb_we_o,
  output logic [REG_SIZE-1:0]  rb_waddr_o,
  output logic [WORD_SIZE-1:0] rb_data_o,
  output logic                 busy_o,
  output logic                 exception_o,
  output logic [ADDR_SIZE-1:0] exc_pc_o
`ifdef SEGRE_HF_PERF_CNT_EN
  ,
  output logic [31:0]          retired_cnt_o,
  output logic [31:0]          stall_cnt_o
`endif
);

  typedef enum logic [1:0] {RUN, ROLLBACK, REDIRECT} state_e;

  state_e              state_q, state_d;
  logic [HF_PTR-1:0]   head_q, head_d, tail_q, tail_d, wp_q, wp_d;
  logic [HF_PTR:0]     count_q, count_d;
  logic [HF_SIZE-1:0]  valid_q, valid_d, done_q, done_d, exc_q, exc_d;

  logic [ADDR_SIZE-1:0] pc_q    [HF_SIZE];
  logic                 rf_we_q [HF_SIZE];
  logic [REG_SIZE-1:0]  waddr_q [HF_SIZE];
  logic [WORD_SIZE-1:0] old_q   [HF_SIZE];

  logic                 ret_vld_q, ret_vld_d;
  logic [HF_PTR-1:0]    ret_id_q, ret_id_d;
  logic                 rb_we_q, rb_we_d;
  logic [REG_SIZE-1:0]  rb_waddr_q, rb_waddr_d;
  logic [WORD_SIZE-1:0] rb_data_q, rb_data_d;
  logic                 exc_out_q, exc_out_d;
  logic [ADDR_SIZE-1:0] exc_pc_q, exc_pc_d;

  logic do_alloc, do_retire, start_rb, head_ready;

  assign full_o     = (count_q == (HF_PTR+1)'(HF_SIZE));
  assign busy_o     = (state_q != RUN);
  assign alloc_id_o = tail_q;

  assign head_ready = valid_q[head_q] && done_q[head_q];
  assign do_alloc   = alloc_i && !full_o && (state_q == RUN);
  assign do_retire  = (state_q == RUN) && head_ready && !exc_q[head_q];
  assign start_rb   = (state_q == RUN) && head_ready && exc_q[head_q];

  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    wp_d       = wp_q;
    valid_d    = valid_q;
    done_d     = done_q;
    exc_d      = exc_q;
    ret_vld_d  = 1'b0;
    ret_id_d   = '0;
    rb_we_d    = 1'b0;
    rb_waddr_d = '0;
    rb_data_d  = '0;
    exc_out_d  = 1'b0;
    exc_pc_d   = '0;
    case (state_q)
      RUN: begin
        // Strobes land first; retire/alloc of the same slot override them.
        if (ex_done_i && valid_q[ex_id_i]) done_d[ex_id_i] = 1'b1;
        if (rvm_done_i && valid_q[rvm_id_i]) done_d[rvm_id_i] = 1'b1;
        if (mem_done_i && valid_q[mem_id_i]) begin
          done_d[mem_id_i] = 1'b1;
          if (mem_exc_i) exc_d[mem_id_i] = 1'b1;
        end
        if (do_retire) begin
          valid_d[head_q] = 1'b0;
          done_d[head_q]  = 1'b0;
          head_d          = head_q + 1'b1;
          ret_vld_d       = 1'b1;
          ret_id_d        = head_q;
        end
        if (do_alloc) begin
          valid_d[tail_q] = 1'b1;
          done_d[tail_q]  = 1'b0;
          exc_d[tail_q]   = 1'b0;
          tail_d          = tail_q + 1'b1;
        end
        if (do_alloc && !do_retire)      count_d = count_q + 1'b1;
        else if (!do_alloc && do_retire) count_d = count_q - 1'b1;
        if (start_rb) begin
          state_d = ROLLBACK;
          wp_d    = tail_d - 1'b1;
        end
      end
      ROLLBACK: begin
        rb_we_d = rf_we_q[wp_q];
        if (rf_we_q[wp_q]) begin
          rb_waddr_d = waddr_q[wp_q];
          rb_data_d  = old_q[wp_q];
        end
        if (wp_q == head_q) state_d = REDIRECT;
        else                wp_d    = wp_q - 1'b1;
      end
      REDIRECT: begin
        exc_out_d = 1'b1;
        exc_pc_d  = pc_q[head_q];
        valid_d   = '0;
        done_d    = '0;
        exc_d     = '0;
        head_d    = '0;
        tail_d    = '0;
        count_d   = '0;
        wp_d      = '0;
        state_d   = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rsn_i) begin
      state_q    <= RUN;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      wp_q       <= '0;
      valid_q    <= '0;
      done_q     <= '0;
      exc_q      <= '0;
      ret_vld_q  <= 1'b0;
      ret_id_q   <= '0;
      rb_we_q    <= 1'b0;
      rb_waddr_q <= '0;
      rb_data_q  <= '0;
      exc_out_q  <= 1'b0;
      exc_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      wp_q       <= wp_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      exc_q      <= exc_d;
      ret_vld_q  <= ret_vld_d;
      ret_id_q   <= ret_id_d;
      rb_we_q    <= rb_we_d;
      rb_waddr_q <= rb_waddr_d;
      rb_data_q  <= rb_data_d;
      exc_out_q  <= exc_out_d;
      exc_pc_q   <= exc_pc_d;
    end
  end

  // Payload storage is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (do_alloc) begin
      pc_q[tail_q]    <= alloc_pc_i;
      rf_we_q[tail_q] <= alloc_rf_we_i;
      waddr_q[tail_q] <= alloc_rf_waddr_i;
      old_q[tail_q]   <= alloc_old_data_i;
    end
  end

  assign retire_valid_o = ret_vld_q;
  assign retire_id_o    = ret_id_q;
  assign rb_we_o        = rb_we_q;
  assign rb_waddr_o     = rb_waddr_q;
  assign rb_data_o      = rb_data_q;
  assign exception_o    = exc_out_q;
  assign exc_pc_o       = exc_pc_q;

`ifdef SEGRE_HF_PERF_CNT_EN
  logic [31:0] retired_cnt_q, stall_cnt_q;
  always_ff @(posedge clk_i) begin
    if (rsn_i) begin
      retired_cnt_q <= '0;
      stall_cnt_q   <= '0;
    end else begin
      if (do_retire) retired_cnt_q <= retired_cnt_q + 32'd1;
      if (alloc_i && (full_o || busy_o)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end
  assign retired_cnt_o = retired_cnt_q;
  assign stall_cnt_o   = stall_cnt_q;
`endif

  a_alloc_ok: assert property (@(posedge clk_i) disable iff (rsn_i || !ALLOC_ASSERT_EN)
    alloc_i |-> !(full_o || busy_o));
  a_ex_valid: assert property (@(posedge clk_i) disable iff (rsn_i)
    (ex_done_i && state_q == RUN) |-> valid_q[ex_id_i]);
  a_mem_valid: assert property (@(posedge clk_i) disable iff (rsn_i)
    (mem_done_i && state_q == RUN) |-> valid_q[mem_id_i]);
  a_rvm_valid: assert property (@(posedge clk_i) disable iff (rsn_i)
    (rvm_done_i && state_q == RUN) |-> valid_q[rvm_id_i]);

endmodule

// File: tb/tb_segre_history_file.sv
// Scoreboard bench for segre_history_file: stimulus pushes expected retire/rollback/redirect
// events, a negedge monitor pops and compares them whenever the DUT presents one.
module tb_segre_history_file;

  logic        clk = 1'b0;
  logic        rsn;
  logic        alloc_i;
  logic [31:0] alloc_pc_i;
  logic        alloc_rf_we_i;
  logic [4:0]  alloc_rf_waddr_i;
  logic [31:0] alloc_old_data_i;
  logic [2:0]  alloc_id_o;
  logic        full_o;
  logic        ex_done_i, mem_done_i, rvm_done_i, mem_exc_i;
  logic [2:0]  ex_id_i, mem_id_i, rvm_id_i;
  logic        retire_valid_o;
  logic [2:0]  retire_id_o;
  logic        rb_we_o;
  logic [4:0]  rb_waddr_o;
  logic [31:0] rb_data_o;
  logic        busy_o, exception_o;
  logic [31:0] exc_pc_o;
`ifdef SEGRE_HF_PERF_CNT_EN
  logic [31:0] retired_cnt_o, stall_cnt_o;
`endif

  segre_history_file #(.HF_SIZE(8), .ADDR_SIZE(32), .WORD_SIZE(32), .REG_SIZE(5),
                       .ALLOC_ASSERT_EN(1'b0)) dut (
    .clk_i(clk), .rsn_i(rsn),
    .alloc_i(alloc_i), .alloc_pc_i(alloc_pc_i), .alloc_rf_we_i(alloc_rf_we_i),
    .alloc_rf_waddr_i(alloc_rf_waddr_i), .alloc_old_data_i(alloc_old_data_i),
    .alloc_id_o(alloc_id_o), .full_o(full_o),
    .ex_done_i(ex_done_i), .mem_done_i(mem_done_i), .rvm_done_i(rvm_done_i),
    .ex_id_i(ex_id_i), .mem_id_i(mem_id_i), .rvm_id_i(rvm_id_i), .mem_exc_i(mem_exc_i),
    .retire_valid_o(retire_valid_o), .retire_id_o(retire_id_o),
    .rb_we_o(rb_we_o), .rb_waddr_o(rb_waddr_o), .rb_data_o(rb_data_o),
    .busy_o(busy_o), .exception_o(exception_o), .exc_pc_o(exc_pc_o)
`ifdef SEGRE_HF_PERF_CNT_EN
    , .retired_cnt_o(retired_cnt_o), .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {int kind; logic [31:0] a; logic [31:0] b;} ev_t;  // 0 retire, 1 rb, 2 exc
  ev_t exp_q[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [31:0] a, input logic [31:0] b);
    ev_t e;
    e.kind = kind; e.a = a; e.b = b;
    exp_q.push_back(e);
  endtask

  task automatic pop_chk(input string name, input int kind, input logic [31:0] a,
                         input logic [31:0] b);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s: unexpected event a=0x%0h b=0x%0h, none expected", name, a, b);
    end else begin
      e = exp_q.pop_front();
      chk({name, "_kind"}, 32'(kind), 32'(e.kind));
      chk({name, "_a"}, a, e.a);
      chk({name, "_b"}, b, e.b);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (retire_valid_o) pop_chk("retire", 0, 32'(retire_id_o), 32'd0);
    if (rb_we_o)        pop_chk("rb", 1, 32'(rb_waddr_o), rb_data_o);
    if (exception_o)    pop_chk("exc", 2, exc_pc_o, 32'd0);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    alloc_i = 1'b0; alloc_pc_i = '0; alloc_rf_we_i = 1'b0; alloc_rf_waddr_i = '0;
    alloc_old_data_i = '0;
    ex_done_i = 1'b0; mem_done_i = 1'b0; rvm_done_i = 1'b0; mem_exc_i = 1'b0;
    ex_id_i = '0; mem_id_i = '0; rvm_id_i = '0;
  endtask

  task automatic do_reset();
    rsn = 1'b1;
    clr();
    repeat (2) cyc();
    chk("rst_retire_valid", 32'(retire_valid_o), 32'd0);
    chk("rst_rb_we", 32'(rb_we_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_exception", 32'(exception_o), 32'd0);
    chk("rst_full", 32'(full_o), 32'd0);
    chk("rst_alloc_id", 32'(alloc_id_o), 32'd0);
    rsn = 1'b0;
  endtask

  task automatic alloc(input logic [31:0] pc, input logic we, input logic [4:0] wa,
                       input logic [31:0] od, input int exp_id);
    alloc_i = 1'b1; alloc_pc_i = pc; alloc_rf_we_i = we; alloc_rf_waddr_i = wa;
    alloc_old_data_i = od;
    chk("alloc_id", 32'(alloc_id_o), 32'(exp_id));
    cyc();
    alloc_i = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) break;
      cyc();
    end
    cyc();
    chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic rb_setup();
    alloc(32'h100, 1'b1, 5'd5, 32'hA, 0);
    alloc(32'h104, 1'b0, 5'd0, 32'h0, 1);
    alloc(32'h108, 1'b1, 5'd7, 32'hB, 2);
    mem_done_i = 1'b1; mem_id_i = 3'd0; mem_exc_i = 1'b1;
    cyc();
    clr();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clr();
    // Out-of-order completion, in-order retire.
    do_reset();
    for (int i = 0; i < 3; i++) alloc(32'h40 + 32'(4*i), 1'b0, 5'd0, 32'd0, i);
    ex_done_i = 1'b1; ex_id_i = 3'd2; cyc(); clr();
    push(0, 32'd0, 32'd0);
    ex_done_i = 1'b1; ex_id_i = 3'd0; cyc(); clr();
    push(0, 32'd1, 32'd0); push(0, 32'd2, 32'd0);
    ex_done_i = 1'b1; ex_id_i = 3'd1; cyc(); clr();
    drain("inorder");

    // Fill, dropped alloc, retire and wrap.
    do_reset();
    for (int i = 0; i < 8; i++) alloc(32'h200 + 32'(4*i), 1'b0, 5'd0, 32'd0, i);
    chk("full_after_8", 32'(full_o), 32'd1);
    alloc_i = 1'b1; alloc_pc_i = 32'h300; cyc(); alloc_i = 1'b0;
    chk("full_after_drop", 32'(full_o), 32'd1);
    push(0, 32'd0, 32'd0);
    ex_done_i = 1'b1; ex_id_i = 3'd0; cyc(); clr();
    cyc();
    chk("full_after_retire", 32'(full_o), 32'd0);
    alloc(32'h304, 1'b0, 5'd0, 32'd0, 0);
    chk("full_after_wrap", 32'(full_o), 32'd1);
    drain("wrap");

    // Three completions in one cycle.
    do_reset();
    for (int i = 0; i < 3; i++) alloc(32'h500 + 32'(4*i), 1'b0, 5'd0, 32'd0, i);
    push(0, 32'd0, 32'd0); push(0, 32'd1, 32'd0); push(0, 32'd2, 32'd0);
    ex_done_i = 1'b1; ex_id_i = 3'd0;
    mem_done_i = 1'b1; mem_id_i = 3'd1;
    rvm_done_i = 1'b1; rvm_id_i = 3'd2;
    cyc(); clr();
    drain("triple");

    // Exception at head: rollback youngest first, then redirect.
    do_reset();
    push(1, 32'd7, 32'hB); push(1, 32'd5, 32'hA); push(2, 32'h100, 32'd0);
    rb_setup();
    chk("busy_before_rb", 32'(busy_o), 32'd0);
    cyc();
    chk("busy_rb_start", 32'(busy_o), 32'd1);
    cyc();
    cyc();
    chk("rb_gap_we", 32'(rb_we_o), 32'd0);
    chk("rb_gap_busy", 32'(busy_o), 32'd1);
    cyc();
    cyc();
    chk("post_exc_full", 32'(full_o), 32'd0);
    chk("post_exc_alloc_id", 32'(alloc_id_o), 32'd0);
    drain("rollback");

    // Reset during the second rollback cycle aborts the walk.
    do_reset();
    push(1, 32'd7, 32'hB);
    rb_setup();
    cyc();
    cyc();
    rsn = 1'b1;
    cyc();
    chk("abort_rb_we", 32'(rb_we_o), 32'd0);
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_rb_data", rb_data_o, 32'd0);
    chk("abort_exception", 32'(exception_o), 32'd0);
    rsn = 1'b0;
    repeat (4) cyc();
    chk("abort_no_events", 32'(exp_q.size()), 32'd0);

`ifdef SEGRE_HF_PERF_CNT_EN
    do_reset();
    for (int i = 0; i < 8; i++) alloc(32'h600 + 32'(4*i), 1'b0, 5'd0, 32'd0, i);
    alloc_i = 1'b1; repeat (2) cyc(); alloc_i = 1'b0;
    for (int i = 0; i < 5; i++) push(0, 32'(i), 32'd0);
    ex_done_i = 1'b1; ex_id_i = 3'd0; mem_done_i = 1'b1; mem_id_i = 3'd1;
    rvm_done_i = 1'b1; rvm_id_i = 3'd2;
    cyc(); clr();
    ex_done_i = 1'b1; ex_id_i = 3'd3; mem_done_i = 1'b1; mem_id_i = 3'd4;
    cyc(); clr();
    drain("perf");
    chk("retired_cnt", retired_cnt_o, 32'd5);
    chk("stall_cnt", stall_cnt_o, 32'd2);
`endif

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
